// File: rtl/ram_burst_reader.sv
// ram_burst_reader: streams a burst of words from a synchronous-read RAM port
// (one cycle read latency) out through a 2-entry FIFO with valid/ready
// handshaking.
// Optional feature: define RD_CHECKSUM_EN to add the 'chk' output, a running
// XOR of every beat accepted in the current burst.
module ram_burst_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              re_b,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
`ifdef RD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] chk
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rd_cnt_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic              inflight_q;

  logic [DATA_W-1:0] fifo_mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        fifo_cnt_q;

  logic [LEN_W-1:0]  beat_cnt_q;
  logic              done_q;

  logic              start_acc;
  logic              pop;
  logic [2:0]        occ_after_pop;
  logic              last_read;
  logic              last_beat;

  // A start request only counts while idle; anything seen while busy is dropped.
  assign start_acc = (state_q == IDLE) && start;

  // State register for the burst sequencer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: issue reads in READ, wait for the tail beats in DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && (len != LEN_W'(0))) begin
          state_d = READ;
        end
      end
      READ: begin
        if (last_read) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_beat) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: stream side from the FIFO head; a read is issued only when
  // FIFO entries (after this cycle's pop) plus the read in flight leave room.
  always_comb begin
    busy          = (state_q != IDLE);
    m_valid       = (fifo_cnt_q != 2'd0);
    m_data        = fifo_mem_q[rd_ptr_q];
    m_last        = m_valid && ((beat_cnt_q + LEN_W'(1)) == len_q);
    pop           = m_valid && m_ready;
    occ_after_pop = {1'b0, fifo_cnt_q} - {2'b00, pop} + {2'b00, inflight_q};
    re_b          = (state_q == READ) && (occ_after_pop < 3'd2);
    addr_b        = re_b ? rd_addr_q : addr_hold_q;
    last_read     = re_b && ((rd_cnt_q + LEN_W'(1)) == len_q);
    last_beat     = pop && m_last;
  end

  // Read-side bookkeeping: burst parameters, issue counter, next address and
  // the one-deep in-flight flag that marks data_b as valid next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q       <= '0;
      rd_cnt_q    <= '0;
      rd_addr_q   <= '0;
      addr_hold_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= re_b;
      if (start_acc) begin
        len_q     <= len;
        rd_cnt_q  <= '0;
        rd_addr_q <= base_addr;
      end else if (re_b) begin
        rd_cnt_q    <= rd_cnt_q + LEN_W'(1);
        rd_addr_q   <= rd_addr_q + ADDR_W'(1);
        addr_hold_q <= rd_addr_q;
      end
    end
  end

  // Two-entry output FIFO, written with the RAM data one cycle after each read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_mem_q[wr_ptr_q] <= data_b;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  // Count accepted beats so the final one can be flagged with m_last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (start_acc) begin
      beat_cnt_q <= '0;
    end else if (pop) begin
      beat_cnt_q <= beat_cnt_q + LEN_W'(1);
    end
  end

  // Completion pulse: after the last beat leaves, or right after a zero-length start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= last_beat || (start_acc && (len == LEN_W'(0)));
    end
  end

  assign done = done_q;

`ifdef RD_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q;

  // Running XOR of accepted beats, restarted by each accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (start_acc) begin
      chk_q <= '0;
    end else if (pop) begin
      chk_q <= chk_q ^ m_data;
    end
  end

  assign chk = chk_q;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Testbench for ram_burst_reader: synchronous RAM model, directed scenarios
// and randomized bursts checked against a queue-based reference of the
// expected address/beat sequence. Works with or without RD_CHECKSUM_EN.
module tb_ram_burst_reader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 5;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy;
  logic              done;
  logic              re_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_b;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready = 1'b0;
`ifdef RD_CHECKSUM_EN
  logic [DATA_W-1:0] chk;
`endif

  logic [DATA_W-1:0] ram [DEPTH];
  int checks = 0;
  int passed = 0;

  ram_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .len(len),
    .busy(busy),
    .done(done),
    .re_b(re_b),
    .addr_b(addr_b),
    .data_b(data_b),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_last(m_last),
    .m_ready(m_ready)
`ifdef RD_CHECKSUM_EN
    ,
    .chk(chk)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears the cycle after re_b; junk otherwise.
  always @(posedge clk) begin
    if (re_b) data_b <= ram[addr_b];
    else      data_b <= DATA_W'($urandom);
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // All externally visible outputs must sit at their reset values.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_re_b"}, re_b, 0);
    checkOutput({tag, "_m_valid"}, m_valid, 0);
    checkOutput({tag, "_m_last"}, m_last, 0);
    checkOutput({tag, "_addr_b"}, addr_b, 0);
    checkOutput({tag, "_m_data"}, m_data, 0);
`ifdef RD_CHECKSUM_EN
    checkOutput({tag, "_chk"}, chk, 0);
`endif
  endtask

  // Runs one burst. mode 0: m_ready always 1; 1: random; 2: low for 'stall'
  // cycles then high. intrude_at: cycle of a second start while busy (-1 none).
  // abort_after: beats to accept before a mid-burst reset (0 none).
  task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l,
                               input int mode, input int stall, input int intrude_at,
                               input int abort_after);
    logic [DATA_W-1:0] exp_q[$];
    int exp_addr[$];
    int rd_seen[$];
    int beats = 0, reads = 0, cyc = 0, last_acc = -1, prev_acc = -1;
    int done_cnt = 0, done_cyc = -1, first_re = -1, reads_in_stall = 0;
    logic [DATA_W-1:0] xsum = '0;
    logic [DATA_W-1:0] held_data = '0;
    logic [DATA_W-1:0] exp_d;
    logic held = 1'b0;
    bit finished = 0;
    bit aborted = 0;
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back(ram[(int'(b) + i) % DEPTH]);
      exp_addr.push_back((int'(b) + i) % DEPTH);
    end
    for (cyc = 0; cyc < 600 && !finished && !aborted; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b1; base_addr = b; len = l;
      end else if (cyc == intrude_at) begin
        start = 1'b1; base_addr = ~b; len = (l == 5'd1) ? 5'd2 : 5'd1;
      end else begin
        start = 1'b0; base_addr = ADDR_W'($urandom); len = LEN_W'($urandom);
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 99) < 60);
        default: m_ready = (cyc > stall);
      endcase
      #1;
      if (held) begin
        checkOutput("hold_valid", m_valid, 1);
        checkOutput("hold_data", m_data, held_data);
      end
      if (cyc == 1) checkOutput("busy_after_start", busy, (l != 0));
      if (re_b) begin
        rd_seen.push_back(int'(addr_b));
        reads++;
        if (first_re < 0) first_re = cyc;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_beat", 1, 0);
        end else begin
          exp_d = exp_q.pop_front();
          checkOutput("m_data", m_data, exp_d);
          checkOutput("m_last", m_last, (beats == int'(l) - 1));
        end
        if (mode == 0 && prev_acc >= 0) checkOutput("beat_gap", cyc - prev_acc, 1);
        prev_acc = cyc;
        last_acc = cyc;
        xsum ^= m_data;
        beats++;
      end
      if (re_b) checkOutput("occupancy_ok", ((reads - beats) <= 2), 1);
      held = m_valid && !m_ready;
      held_data = m_data;
      if (mode == 2 && cyc == stall) reads_in_stall = reads;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        checkOutput("busy_at_done", busy, 0);
        finished = 1;
      end
      if (abort_after > 0 && beats >= abort_after) aborted = 1;
    end
    start = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b0;
      m_ready = 1'b0;
      @(negedge clk);
      #1;
      checkResetValues("abort");
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        #1;
        checkOutput("abort_no_done", done, 0);
      end
      return;
    end
    if (!finished) checkOutput("timeout_done", 0, 1);
    checkOutput("beat_count", beats, int'(l));
    checkOutput("read_count", reads, int'(l));
    checkOutput("done_count", done_cnt, 1);
    for (int i = 0; i < rd_seen.size() && i < exp_addr.size(); i++)
      checkOutput("rd_addr", rd_seen[i], exp_addr[i]);
    if (l == 0) checkOutput("zero_len_done_cycle", done_cyc, 1);
    else        checkOutput("done_latency", done_cyc, last_acc + 1);
    if (mode == 0 && l != 0) checkOutput("first_re_cycle", first_re, 1);
    if (mode == 2 && l >= 2) checkOutput("stall_reads", reads_in_stall, 2);
`ifdef RD_CHECKSUM_EN
    checkOutput("chk", chk, xsum);
`endif
    @(negedge clk);
    #1;
    checkOutput("done_one_cycle", done, 0);
    checkOutput("idle_after_done", busy, 0);
  endtask

  // Main sequence: reset, directed scenarios, then randomized bursts.
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'($urandom);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);

    ram[3] = 8'hAA; ram[4] = 8'h55;
    applyStimulus(4'd3, 5'd2, 0, 0, -1, 0);

    ram[15] = 8'h11; ram[0] = 8'h22; ram[1] = 8'h33;
    applyStimulus(4'd15, 5'd3, 0, 0, -1, 0);

    applyStimulus(4'd0, 5'd4, 2, 10, -1, 0);

    applyStimulus(4'd6, 5'd0, 0, 0, -1, 0);

    applyStimulus(4'd9, 5'd16, 1, 0, 5, 0);

    applyStimulus(4'd2, 5'd8, 0, 0, -1, 2);
    applyStimulus(4'd5, 5'd1, 0, 0, -1, 0);

    for (int n = 0; n < 25; n++) begin
      if (n % 5 == 0)
        for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'($urandom);
      applyStimulus(ADDR_W'($urandom_range(0, 15)), LEN_W'($urandom_range(1, 16)),
                    $urandom_range(0, 1), 0, -1, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
